// File: rtl/ad9783_spi_ctrl.sv
// AD9783 DAC pair configuration sequencer.
// Turns one-cycle host commands into 16-bit SPI frames (instruction byte plus
// one data byte) on a shared SCK/SDO/SDI with per-chip chip selects, and owns
// the DAC hardware RESET pins (timed pulse after reset and on soft reset).
module ad9783_spi_ctrl #(
   parameter int SCK_DIV    = 8,
   parameter int RST_CYCLES = 100
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        cmd_trig_in,
   input  logic [15:0] cmd_addr_in,
   input  logic [15:0] cmd_data_in,
   output logic [15:0] cmd_data_out,
   output logic        cmd_busy_out,
   output logic        cmd_done_out,
   output logic        rst0_out,
   output logic        rst1_out,
   output logic        spi_scs0_out,
   output logic        spi_scs1_out,
   output logic        spi_sck_out,
   output logic        spi_sdo_out,
   input  logic        spi_sdi_in
);

   localparam int CNT_MAX = (RST_CYCLES > SCK_DIV) ? RST_CYCLES : SCK_DIV;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(SCK_DIV - 1);
   localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [2:0] {
      ST_RST_HOLD = 3'd0,
      ST_RST_WAIT = 3'd1,
      ST_IDLE     = 3'd2,
      ST_CS_SETUP = 3'd3,
      ST_SHIFT    = 3'd4,
      ST_CS_HOLD  = 3'd5,
      ST_DONE     = 3'd6
   } state_t;

   state_t          state_r, state_s;
   logic [CW-1:0]   cnt_r, cnt_s;
   logic [3:0]      bit_r, bit_s;
   logic            high_r, high_s;
   logic [15:0]     frame_r, frame_s;
   logic            soft_r, soft_s;
   logic [7:0]      rx_r, rx_s;
   logic [7:0]      rdata_r, rdata_s;
   logic            sdi_r;
   logic            busy_r, busy_s;
   logic            done_r, done_s;
   logic            dropped_r, dropped_s;
   logic            rst_r, rst_s;
   logic            scs0_r, scs0_s;
   logic            scs1_r, scs1_s;
   logic            sck_r, sck_s;
   logic            sdo_r, sdo_s;

   // Bit k of the frame as driven on SDO; the data byte of a read is sent as zero.
   function automatic logic tx_bit(input logic [15:0] frame, input logic [3:0] k);
      logic b;
      if (frame[15] && (k < 4'd8)) begin
         b = 1'b0;
      end else begin
         b = frame[k];
      end
      return b;
   endfunction

   // Readback line is registered once before it is shifted in.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         sdi_r <= 1'b0;
      end else begin
         sdi_r <= spi_sdi_in;
      end
   end

   // State, counters and registered output pins.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_r   <= ST_RST_HOLD;
         cnt_r     <= CNT_ZERO;
         bit_r     <= 4'd15;
         high_r    <= 1'b0;
         frame_r   <= 16'h0000;
         soft_r    <= 1'b0;
         rx_r      <= 8'h00;
         rdata_r   <= 8'h00;
         busy_r    <= 1'b1;
         done_r    <= 1'b0;
         dropped_r <= 1'b0;
         rst_r     <= 1'b1;
         scs0_r    <= 1'b1;
         scs1_r    <= 1'b1;
         sck_r     <= 1'b0;
         sdo_r     <= 1'b0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         bit_r     <= bit_s;
         high_r    <= high_s;
         frame_r   <= frame_s;
         soft_r    <= soft_s;
         rx_r      <= rx_s;
         rdata_r   <= rdata_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
         dropped_r <= dropped_s;
         rst_r     <= rst_s;
         scs0_r    <= scs0_s;
         scs1_r    <= scs1_s;
         sck_r     <= sck_s;
         sdo_r     <= sdo_s;
      end
   end

   // Next-state logic; outputs are computed one cycle ahead so every pin is a flop.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      bit_s     = bit_r;
      high_s    = high_r;
      frame_s   = frame_r;
      soft_s    = soft_r;
      rx_s      = rx_r;
      rdata_s   = rdata_r;
      busy_s    = busy_r;
      done_s    = 1'b0;
      dropped_s = dropped_r;
      rst_s     = rst_r;
      scs0_s    = scs0_r;
      scs1_s    = scs1_r;
      sck_s     = sck_r;
      sdo_s     = sdo_r;

      // Commands arriving while busy are discarded but remembered.
      if (cmd_trig_in && (state_r != ST_IDLE)) begin
         dropped_s = 1'b1;
      end else begin
         dropped_s = dropped_r;
      end

      case (state_r)
         ST_RST_HOLD: begin
            if (cnt_r == RST_LAST) begin
               state_s = ST_RST_WAIT;
               cnt_s   = CNT_ZERO;
               rst_s   = 1'b0;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         ST_RST_WAIT: begin
            if (cnt_r == RST_LAST) begin
               state_s = ST_IDLE;
               cnt_s   = CNT_ZERO;
               busy_s  = 1'b0;
               done_s  = soft_r;
               soft_s  = 1'b0;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         ST_IDLE: begin
            if (cmd_trig_in) begin
               dropped_s = 1'b0;
               busy_s    = 1'b1;
               cnt_s     = CNT_ZERO;
               if (cmd_addr_in[14]) begin
                  state_s = ST_RST_HOLD;
                  soft_s  = 1'b1;
                  rst_s   = 1'b1;
               end else begin
                  state_s = ST_CS_SETUP;
                  frame_s = {cmd_addr_in[15], 2'b00, cmd_addr_in[4:0], cmd_data_in[7:0]};
                  scs0_s  = cmd_addr_in[8];
                  scs1_s  = ~cmd_addr_in[8];
                  sdo_s   = cmd_addr_in[15];
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_CS_SETUP: begin
            if (cnt_r == DIV_LAST) begin
               state_s = ST_SHIFT;
               cnt_s   = CNT_ZERO;
               bit_s   = 4'd15;
               high_s  = 1'b0;
               sdo_s   = tx_bit(frame_r, 4'd15);
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         ST_SHIFT: begin
            if (!high_r) begin
               if (cnt_r == DIV_LAST) begin
                  cnt_s  = CNT_ZERO;
                  high_s = 1'b1;
                  sck_s  = 1'b1;
               end else begin
                  cnt_s = cnt_r + CNT_ONE;
               end
            end else begin
               if (cnt_r == DIV_LAST) begin
                  cnt_s = CNT_ZERO;
                  sck_s = 1'b0;
                  if (frame_r[15] && (bit_r < 4'd8)) begin
                     rx_s = {rx_r[6:0], sdi_r};
                  end else begin
                     rx_s = rx_r;
                  end
                  if (bit_r == 4'd0) begin
                     state_s = ST_CS_HOLD;
                     sdo_s   = 1'b0;
                  end else begin
                     bit_s  = bit_r - 4'd1;
                     high_s = 1'b0;
                     sdo_s  = tx_bit(frame_r, bit_r - 4'd1);
                  end
               end else begin
                  cnt_s = cnt_r + CNT_ONE;
               end
            end
         end
         ST_CS_HOLD: begin
            if (cnt_r == DIV_LAST) begin
               state_s = ST_DONE;
               cnt_s   = CNT_ZERO;
               scs0_s  = 1'b1;
               scs1_s  = 1'b1;
               done_s  = 1'b1;
               if (frame_r[15]) begin
                  rdata_s = rx_r;
               end else begin
                  rdata_s = rdata_r;
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
         end
         default: begin
            state_s = ST_RST_HOLD;
            cnt_s   = CNT_ZERO;
            rst_s   = 1'b1;
            busy_s  = 1'b1;
            scs0_s  = 1'b1;
            scs1_s  = 1'b1;
            sck_s   = 1'b0;
            sdo_s   = 1'b0;
         end
      endcase
   end

   assign cmd_data_out = {busy_r, dropped_r, 6'b000000, rdata_r};
   assign cmd_busy_out = busy_r;
   assign cmd_done_out = done_r;
   assign rst0_out     = rst_r;
   assign rst1_out     = rst_r;
   assign spi_scs0_out = scs0_r;
   assign spi_scs1_out = scs1_r;
   assign spi_sck_out  = sck_r;
   assign spi_sdo_out  = sdo_r;

endmodule

// File: tb/tb_ad9783_spi_ctrl.sv
// Directed bench for ad9783_spi_ctrl: power-on, write, read with SDI model,
// dropped commands, soft reset and asynchronous reset mid-frame.
module tb_ad9783_spi_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        trig = 1'b0;
   logic [15:0] addr = 16'h0000;
   logic [15:0] data = 16'h0000;
   logic [15:0] data_out;
   logic        busy, done, rst0, rst1, scs0, scs1, sck, sdo;
   logic        sdi = 1'b0;

   int total = 0;
   int bad = 0;

   // bus monitor state
   int          rises_total = 0;
   int          frame_rises = 0;
   int          scs0_low = 0;
   int          scs1_low = 0;
   int          done_total = 0;
   int          viol = 0;
   logic        sck_prev = 1'b0;
   logic [15:0] sdo_cap = 16'h0000;
   logic [7:0]  sdi_byte = 8'h3C;

   ad9783_spi_ctrl dut (
      .clk_in       (clk),
      .rst_n_in     (rst_n),
      .cmd_trig_in  (trig),
      .cmd_addr_in  (addr),
      .cmd_data_in  (data),
      .cmd_data_out (data_out),
      .cmd_busy_out (busy),
      .cmd_done_out (done),
      .rst0_out     (rst0),
      .rst1_out     (rst1),
      .spi_scs0_out (scs0),
      .spi_scs1_out (scs1),
      .spi_sck_out  (sck),
      .spi_sdo_out  (sdo),
      .spi_sdi_in   (sdi)
   );

   always #5 clk = ~clk;

   function automatic logic sdi_for(input int r, input logic [7:0] b);
      if (r >= 8 && r < 16) return b[15 - r];
      return 1'b0;
   endfunction

   // Watches the SPI pins on the falling clock edge and plays the DAC's SDI.
   always @(negedge clk) begin : mon
      int fr_n;
      fr_n = frame_rises;
      if (sck && !sck_prev) begin
         rises_total <= rises_total + 1;
         sdo_cap     <= {sdo_cap[14:0], sdo};
         fr_n        = fr_n + 1;
      end
      if (scs0 && scs1) fr_n = 0;
      frame_rises <= fr_n;
      if (!sck) sdi <= sdi_for(fr_n, sdi_byte);
      if (!scs0) scs0_low <= scs0_low + 1;
      if (!scs1) scs1_low <= scs1_low + 1;
      if (done) done_total <= done_total + 1;
      if ((!scs0 && !scs1) || (scs0 && scs1 && sck)) viol <= viol + 1;
      sck_prev <= sck;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Hold reset, check the forced state, release and time the DAC reset pulse.
   task automatic power_on(input string tag);
      int hi, lo, d0, s0, s1, r0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_val({tag, "_rst_pins"}, {25'd0, rst0, rst1, scs0, scs1, sck, sdo, done}, 32'b1111000);
      check_val({tag, "_rst_dout"}, {16'h0000, data_out}, 32'h0000_8000);
      d0 = done_total; s0 = scs0_low; s1 = scs1_low; r0 = rises_total;
      rst_n = 1'b1;
      hi = 0; lo = 0;
      for (int i = 0; i < 1000; i++) begin
         if (rst0 && rst1) hi++;
         else if (busy) lo++;
         else break;
         @(negedge clk);
      end
      check_val({tag, "_hold"}, hi, 100);
      check_val({tag, "_wait"}, lo, 100);
      check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check_val({tag, "_nodone"}, {31'd0, done}, 32'd0);
      check_val({tag, "_quiet"}, (done_total - d0) + (scs0_low - s0) + (scs1_low - s1) + (rises_total - r0), 0);
   endtask

   // Issue one frame at the current negedge and check its bus activity.
   task automatic run_frame(input logic [15:0] a, input logic [15:0] d, input int mid_at,
                            input logic [15:0] exp_sdo, input string tag);
      int n, d0, s0, s1, r0, sel_low, oth_low;
      d0 = done_total; s0 = scs0_low; s1 = scs1_low; r0 = rises_total;
      addr = a; data = d; trig = 1'b1;
      n = 0;
      while (n < 400) begin
         @(negedge clk);
         trig = 1'b0;
         n++;
         if (n == mid_at) begin
            addr = 16'h0001; data = 16'h0077; trig = 1'b1;
         end
         if (done) break;
      end
      sel_low = a[8] ? (scs1_low - s1) : (scs0_low - s0);
      oth_low = a[8] ? (scs0_low - s0) : (scs1_low - s1);
      check_val({tag, "_latency"}, n, 273);
      check_val({tag, "_scs_sel"}, sel_low, 272);
      check_val({tag, "_scs_oth"}, oth_low, 0);
      check_val({tag, "_rises"}, rises_total - r0, 16);
      check_val({tag, "_sdo"}, {16'h0000, sdo_cap}, {16'h0000, exp_sdo});
      @(negedge clk);
      check_val({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
      check_val({tag, "_done1"}, done_total - d0, 1);
   endtask

   initial begin
      int n, hi, lo, d0;
      #2;
      // 1. power-on sequence
      power_on("por");
      // 2. write DAC0 addr 0x02 data 0xA5
      run_frame(16'h0002, 16'h00A5, 0, 16'h02A5, "wr0");
      check_val("wr0_dout", data_out, 16'h0000);
      // 3. read DAC1 addr 0x1F, SDI model returns 0x3C
      run_frame(16'h811F, 16'h0000, 0, 16'h9F00, "rd1");
      check_val("rd1_dout", data_out, 16'h003C);
      // 4. trig mid-frame is dropped; frame unaffected; rdata held across write
      run_frame(16'h0003, 16'h005A, 60, 16'h035A, "wrdrop");
      check_val("wrdrop_dout", data_out, 16'h403C);
      run_frame(16'h0110, 16'h00FF, 0, 16'h10FF, "wrclr");
      check_val("wrclr_dout", data_out, 16'h003C);
      // 5. soft reset (with a dropped trig during the wait phase)
      d0 = done_total;
      addr = 16'h4100; trig = 1'b1;
      n = 0; hi = 0; lo = 0;
      while (n < 1000) begin
         @(negedge clk);
         trig = 1'b0;
         n++;
         if (n == 150) trig = 1'b1;
         if (!busy) break;
         if (rst0 && rst1) hi++;
         else if (!done) lo++;
      end
      check_val("srst_hold", hi, 100);
      check_val("srst_wait", lo, 100);
      check_val("srst_len", n, 201);
      check_val("srst_done", {31'd0, done}, 32'd1);
      @(negedge clk);
      check_val("srst_pulse", {31'd0, done}, 32'd0);
      check_val("srst_done1", done_total - d0, 1);
      check_val("srst_dout", data_out, 16'h403C);
      // 6. async reset during bit 9 of a write
      d0 = done_total;
      addr = 16'h0007; data = 16'h0011; trig = 1'b1;
      @(negedge clk);
      trig = 1'b0;
      repeat (109) @(negedge clk);
      check_val("ar_inframe", {31'd0, scs0}, 32'd0);
      rst_n = 1'b0;
      #1;
      check_val("ar_pins", {27'd0, scs0, scs1, sck, rst0, rst1}, 32'b11011);
      check_val("ar_busy", {31'd0, busy}, 32'd1);
      power_on("por2");
      check_val("ar_nodone", done_total - d0, 0);
      check_val("bus_rules", viol, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ad9783_spi_ctrl.md
Name: ad9783_spi_ctrl

Overview:
SPI configuration sequencer for the dual AD9783 DAC pair on the KX1 board. It turns single-cycle host commands (trig/addr/data bus) into 16-bit AD9783 SPI frames on a shared SCK/SDO/SDI with a per-chip chip-select. It also drives the per-chip hardware RESET pins: a timed reset pulse after system reset, and on command. It sits beside the LVDS data-path block and owns all DAC control pins except the LVDS lanes.

Parameters:
SCK_DIV, 8, clk_in cycles per SCK half-period (legal range 2..255); 100 MHz gives 6.25 MHz SCK.
RST_CYCLES, 100, clk_in cycles of DAC RESET assertion; also the post-release wait before IDLE.

Ports:
clk_in  input  1  system clock; all logic is on its rising edge.
rst_n_in  input  1  asynchronous active-low reset.
cmd_trig_in  input  1  one-cycle command strobe.
cmd_addr_in  input  16  [4:0] register addr; [8] chip select (0=DAC0, 1=DAC1); [14] soft reset; [15] read (1) / write (0); other bits ignored.
cmd_data_in  input  16  [7:0] write byte; [15:8] ignored.
cmd_data_out  output  16  {busy, dropped, 6'b0, rdata[7:0]}.
cmd_busy_out  output  1  high when not in IDLE.
cmd_done_out  output  1  one-cycle pulse when a frame or soft reset completes.
rst0_out, rst1_out  output  1 each  DAC hardware RESET, active-high.
spi_scs0_out, spi_scs1_out  output  1 each  active-low chip selects.
spi_sck_out  output  1  SPI clock; idles low.
spi_sdo_out  output  1  serial data to DACs, MSB first.
spi_sdi_in  input  1  serial readback from DACs.

Behaviour:
- While rst_n_in is low, outputs are forced asynchronously to: rst0/rst1=1, scs0/scs1=1, sck=0, sdo=0, busy=1, done=0, dropped=0, rdata=0x00. State = RST_HOLD, counter=0.
- RST_HOLD: rst0/rst1 high for RST_CYCLES cycles, then both go low. Next state RST_WAIT.
- RST_WAIT: waits RST_CYCLES cycles, then enters IDLE with busy=0. After a power-on reset, done is not pulsed.
- IDLE, trig=1, addr[14]=1: latch the soft-reset request and enter RST_HOLD (same timing as above). On exit from RST_WAIT, pulse done for one cycle. Both DACs are reset regardless of addr[8].
- IDLE, trig=1, addr[14]=0:
  - Latch the frame {addr[15], 2'b00, addr[4:0], data[7:0]}. Byte count N=00 means 1 byte.
  - Latch chip = addr[8] and clear dropped.
  - Next cycle: the selected scs goes low; the other stays high. State CS_SETUP.
- CS_SETUP: SCK_DIV cycles with sck=0 and sdo=frame[15]. Then SHIFT.
- SHIFT, per bit k=15..0:
  - Low half: SCK_DIV cycles with sck=0. sdo = frame[k], updated in the first cycle of the low half.
  - High half: SCK_DIV cycles with sck=1.
  - For a read, during bits 7..0: register spi_sdi_in once, and capture the registered value into the shift register in the last cycle of the high half. The byte is assembled MSB first.
  - For a read, sdo=0 during the data byte.
- After bit 0's high half: sck=0, CS_HOLD for SCK_DIV cycles. Then scs is deasserted and the block enters DONE.
- DONE: one cycle. done=1; for a read only, rdata is updated. Returns to IDLE, and busy falls in the same cycle that IDLE is entered.
- Frame timing: scs is low for exactly 34*SCK_DIV cycles. From trig to done is 34*SCK_DIV+1 cycles.
- trig while busy (including during RST_HOLD/RST_WAIT): the command is ignored and dropped=1. dropped is sticky until the next accepted command.
- trig in the same cycle that busy falls: busy is already 0 in that cycle, so the command is accepted.
- Only one scs is ever low at a time. sck never toggles while both scs are high.
- Asynchronous reset mid-frame: scs returns high immediately, the frame is abandoned with no done pulse, and the power-on sequence restarts.
- rdata holds its value across writes; only a completed read updates it.

Test Plan:
1. Power-on: release rst_n_in with RST_CYCLES=100 -> rst0/rst1 high for 100 cycles, low for 100 cycles, then busy=0. scs/sck stay idle throughout and no done pulse occurs.
2. Write DAC0 addr 0x02 data 0xA5, SCK_DIV=8 -> scs0 low for 272 cycles, scs1 high, 16 rising SCK edges. SDO sampled at rising edges = 0x02A5. done arrives 273 cycles after trig.
3. Read DAC1 addr 0x1F (cmd_addr_in=0x811F) with an SDI model returning 0x3C -> instruction byte 0x9F, scs1 only low, cmd_data_out=0x003C after done.
4. trig during a frame -> frame unaffected and cmd_data_out[14]=1. Next accepted write clears it.
5. Soft reset (cmd_addr_in=0x4000) -> rst0 and rst1 pulse for 100 cycles, a 100-cycle wait follows, then a single done pulse.
6. Assert rst_n_in at bit 9 of a write -> scs0=1, sck=0, rst0/rst1=1 immediately, and no done pulse. The power-on sequence repeats.
